// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice LSB first and assembles result and flags.
// Optional one-deep request buffer enabled with `define ALU_SERIAL_PENDING_EN (adds pending_o).
module alu_serial_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [3:0]       ctrl_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             slice_src1_o,
   output logic             slice_src2_o,
   output logic             slice_less_o,
   output logic             slice_A_invert_o,
   output logic             slice_B_invert_o,
   output logic             slice_cin_o,
   output logic [1:0]       slice_operation_o,
   input  logic             slice_result_i,
   input  logic             slice_cout_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             cout_o,
   output logic             overflow_o
`ifdef ALU_SERIAL_PENDING_EN
   ,
   output logic             pending_o
`endif
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       ctrl_q;
   logic [WIDTH-2:0] res_sh_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, cout_q, ovf_q;

   logic             load;
   logic [3:0]       ld_ctrl;
   logic [WIDTH-1:0] ld_a, ld_b;
   logic             is_arith, last_bit, ovf_msb;
   logic [WIDTH-1:0] word, fin_result;
   logic             fin_cout, fin_ovf;

`ifdef ALU_SERIAL_PENDING_EN
   logic             pend_q;
   logic [3:0]       pend_ctrl_q;
   logic [WIDTH-1:0] pend_a_q, pend_b_q;
`endif

   assign is_arith = ctrl_q inside {OP_ADD, OP_SUB, OP_SLT};
   assign last_bit = (state_q == ST_RUN) && (idx_q == LAST_IDX);

   // Request source: live inputs from IDLE, or the buffered request when leaving DONE.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      load    = 1'b0;
      ld_ctrl = ctrl_i;
      ld_a    = src1_i;
      ld_b    = src2_i;
      if (state_q == ST_IDLE && start_i) load = 1'b1;
`ifdef ALU_SERIAL_PENDING_EN
      if (state_q == ST_DONE) begin
         if (pend_q) begin
            load    = 1'b1;
            ld_ctrl = pend_ctrl_q;
            ld_a    = pend_a_q;
            ld_b    = pend_b_q;
         end else if (start_i) begin
            load = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (load) state_d = ST_RUN;
         ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_DONE;
         ST_DONE: state_d = load ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      slice_src1_o      = 1'b0;
      slice_src2_o      = 1'b0;
      slice_A_invert_o  = 1'b0;
      slice_B_invert_o  = 1'b0;
      slice_cin_o       = 1'b0;
      slice_operation_o = 2'b00;
      if (state_q == ST_RUN) begin
         slice_src1_o      = a_q[0];
         slice_src2_o      = b_q[0];
         slice_A_invert_o  = ctrl_q[3];
         slice_B_invert_o  = ctrl_q[2];
         // SLT runs the slice as a subtractor; the less input is not used serially.
         slice_operation_o = (ctrl_q == OP_SLT) ? 2'b10 : ctrl_q[1:0];
         if (is_arith) slice_cin_o = (idx_q == '0) ? ctrl_q[2] : carry_q;
      end
   end

   assign slice_less_o = 1'b0;

   // Final word and flags, evaluated during the MSB cycle from the live slice outputs.
   assign word    = {slice_result_i, res_sh_q};
   assign ovf_msb = slice_cin_o ^ slice_cout_i;

   always_comb begin
      fin_result = word;
      fin_cout   = 1'b0;
      fin_ovf    = 1'b0;
      case (ctrl_q)
         OP_ADD, OP_SUB: begin
            fin_cout = slice_cout_i;
            fin_ovf  = ovf_msb;
         end
         OP_SLT: begin
            fin_result = {{(WIDTH-1){1'b0}}, slice_result_i ^ ovf_msb};
            fin_cout   = slice_cout_i;
         end
         OP_AND, OP_OR, OP_NOR, OP_NAND: ;
         default: fin_result = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         res_sh_q <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (load) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= ld_a;
         b_q     <= ld_b;
         ctrl_q  <= ld_ctrl;
      end else if (state_q == ST_RUN) begin
         idx_q    <= idx_q + CNT_W'(1);
         carry_q  <= slice_cout_i;
         a_q      <= a_q >> 1;
         b_q      <= b_q >> 1;
         res_sh_q <= word[WIDTH-1:1];
         if (last_bit) begin
            result_q <= fin_result;
            zero_q   <= (fin_result == '0);
            cout_q   <= fin_cout;
            ovf_q    <= fin_ovf;
         end
      end
   end

`ifdef ALU_SERIAL_PENDING_EN
   // A start during DONE with an empty buffer is loaded directly, so only RUN captures.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pend_q      <= 1'b0;
         pend_ctrl_q <= '0;
         pend_a_q    <= '0;
         pend_b_q    <= '0;
      end else if (state_q == ST_DONE) begin
         pend_q <= 1'b0;
      end else if (state_q == ST_RUN && start_i && !pend_q) begin
         pend_q      <= 1'b1;
         pend_ctrl_q <= ctrl_i;
         pend_a_q    <= src1_i;
         pend_b_q    <= src2_i;
      end
   end

   assign pending_o = pend_q;
`endif

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = (state_q == ST_DONE);
   assign result_o   = result_q;
   assign zero_o     = zero_q;
   assign cout_o     = cout_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: models the external 1-bit slice and predicts results arithmetically.
// Exercises the request buffer too when ALU_SERIAL_PENDING_EN is defined.
module tb_alu_serial_ctrl;
   localparam int W = 32;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_NAND = 4'b1101;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      int           done_cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [3:0]   ctrl = '0;
   logic [W-1:0] src1 = '0, src2 = '0;
   logic         s_src1, s_src2, s_less, s_ainv, s_binv, s_cin;
   logic [1:0]   s_op;
   logic         s_result, s_cout;
   logic         busy_o, done_o, zero_o, cout_o, overflow_o;
   logic [W-1:0] result_o;
`ifdef ALU_SERIAL_PENDING_EN
   logic         pending_o;
`endif

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic         prev_done = 1'b0;
   logic [W-1:0] last_res = '0;
   exp_t         sb_q[$];

   alu_serial_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .ctrl_i(ctrl),
      .src1_i(src1), .src2_i(src2),
      .slice_src1_o(s_src1), .slice_src2_o(s_src2), .slice_less_o(s_less),
      .slice_A_invert_o(s_ainv), .slice_B_invert_o(s_binv),
      .slice_cin_o(s_cin), .slice_operation_o(s_op),
      .slice_result_i(s_result), .slice_cout_i(s_cout),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
      .zero_o(zero_o), .cout_o(cout_o), .overflow_o(overflow_o)
`ifdef ALU_SERIAL_PENDING_EN
      , .pending_o(pending_o)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External 1-bit ALU slice.
   logic sa, sb;
   always_comb begin
      sa = s_src1 ^ s_ainv;
      sb = s_src2 ^ s_binv;
      case (s_op)
         2'b00:   s_result = sa & sb;
         2'b01:   s_result = sa | sb;
         2'b10:   s_result = sa ^ sb ^ s_cin;
         default: s_result = s_less;
      endcase
      s_cout = (sa & sb) | (sa & s_cin) | (sb & s_cin);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [W:0]   s;
      e.res = '0; e.cout = 1'b0; e.ovf = 1'b0; e.done_cyc = 0;
      case (c)
         OP_AND:  e.res = a & b;
         OP_OR:   e.res = a | b;
         OP_NOR:  e.res = ~(a | b);
         OP_NAND: e.res = ~(a & b);
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         OP_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            e.res  = s[W-1:0];
            e.cout = s[W];
            e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
         end
         OP_SLT: begin
            s = {1'b0, a} + {1'b0, ~b} + 1;
            e.res  = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            e.cout = s[W];
         end
         default: ;
      endcase
      return e;
   endfunction

   // Monitor: every done_o pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done_o) begin
         check("done_single_cycle", prev_done, 1'b0);
         check("busy_in_done", busy_o, 1'b1);
         if (sb_q.size() == 0) begin
            check("spurious_done", done_o, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check("result", result_o, e.res);
            check("zero", zero_o, (e.res == '0));
            check("cout", cout_o, e.cout);
            check("overflow", overflow_o, e.ovf);
            check("done_cycle", cyc, e.done_cyc);
         end
      end
      prev_done = done_o;
   end

   task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   t = 0;
      while (busy_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy_o) check("idle_wait_timeout", busy_o, 1'b0);
      ctrl = c; src1 = a; src2 = b; start = 1'b1;
      e = model(c, a, b);
      e.done_cyc = cyc + W + 1;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", busy_o, 1'b1);
      check("result_held_at_accept", result_o, last_res);
      last_res = e.res;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      @(negedge clk);
   endtask

   logic [3:0]   ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_NAND, 4'b0011};
   logic [W-1:0] corners [5] = '{32'h0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1};

   function automatic logic [W-1:0] pick();
      if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
      return $urandom;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_busy", busy_o, 1'b0);
      check("reset_done", done_o, 1'b0);
      check("reset_result", result_o, 0);
      check("reset_flags", {zero_o, cout_o, overflow_o}, 3'b100);
      check("reset_slice", {s_src1, s_src2, s_less, s_ainv, s_binv, s_cin, s_op}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Abort mid-operation with an asynchronous reset.
      issue(OP_ADD, 32'd5, 32'd7);
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy_o, 1'b0);
      check("abort_done", done_o, 1'b0);
      check("abort_result", result_o, 0);
      check("abort_zero", zero_o, 1'b1);
      check("abort_slice", {s_src1, s_src2, s_ainv, s_binv, s_cin, s_op}, 0);
      sb_q.delete();
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(OP_ADD, 32'd5, 32'd7);
      drain();

      issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);         drain();
      issue(OP_SUB, 32'd5, 32'd5);                  drain();
      issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);          drain();
      issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000);  drain();
      issue(OP_NOR, 32'hF0F0_F0F0, 32'h0F0F_0F00);  drain();
      issue(OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_0000); drain();

`ifdef ALU_SERIAL_PENDING_EN
      begin
         exp_t e1, e2;
         ctrl = OP_ADD; src1 = 32'd1; src2 = 32'd2; start = 1'b1;
         e1 = model(OP_ADD, 32'd1, 32'd2);
         e1.done_cyc = cyc + W + 1;
         sb_q.push_back(e1);
         @(negedge clk);
         start = 1'b0;
         repeat (3) @(negedge clk);
         ctrl = OP_SUB; src1 = 32'd9; src2 = 32'd4; start = 1'b1;
         e2 = model(OP_SUB, 32'd9, 32'd4);
         e2.done_cyc = e1.done_cyc + W + 1;
         sb_q.push_back(e2);
         @(negedge clk);
         start = 1'b0;
         check("pending_set", pending_o, 1'b1);
         repeat (2) @(negedge clk);
         ctrl = OP_AND; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("pending_full_hold", pending_o, 1'b1);
         last_res = e2.res;
         drain();
         check("pending_cleared", pending_o, 1'b0);
         repeat (40) @(negedge clk);
      end
`else
      issue(OP_ADD, 32'd100, 32'd23);
      repeat (5) @(negedge clk);
      ctrl = OP_SUB; src1 = 32'd9; src2 = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_start_ignored", busy_o, 1'b1);
      drain();
      repeat (40) @(negedge clk);
`endif

      for (int i = 0; i < 40; i++) begin
         issue(ops[$urandom_range(7)], pick(), pick());
         drain();
      end

      check("idle_at_end", busy_o, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Sequencer that runs a full-width ALU operation through one external 1-bit ALU slice, one bit per clock, LSB first.
- Latches the operands and the 4-bit ALU control, and drives the slice's A_invert, B_invert, operation, cin and operand bits.
- Holds the carry between cycles, assembles the result word, and produces the zero, carry-out and overflow flags.
- Also performs the SLT fix-up. Sits between the decode stage and a shared bit-slice in the area-reduced datapath.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 2.
- CNT_W, 5: bit-index counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk_i  in  1  Clock; all state updates on the rising edge.
- rst_i  in  1  Reset, asynchronous, active-low; clears all state.
- start_i  in  1  Request; accepted only in IDLE.
- ctrl_i  in  4  ALU control: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- src1_i  in  WIDTH  Operand A, sampled when the request is accepted.
- src2_i  in  WIDTH  Operand B, sampled when the request is accepted.
- slice_src1_o  out  1  Current A bit.
- slice_src2_o  out  1  Current B bit.
- slice_less_o  out  1  Tied 0.
- slice_A_invert_o  out  1  Latched ctrl[3].
- slice_B_invert_o  out  1  Latched ctrl[2].
- slice_cin_o  out  1  Slice carry in.
- slice_operation_o  out  2  Slice operation select.
- slice_result_i  in  1  Slice result bit.
- slice_cout_i  in  1  Slice carry out.
- busy_o  out  1  High in RUN and DONE.
- done_o  out  1  One-cycle completion pulse.
- result_o  out  WIDTH  Final result.
- zero_o  out  1  High when result_o is 0.
- cout_o  out  1  Carry out of the MSB.
- overflow_o  out  1  Signed overflow.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; counter, carry and shift registers clear.
  - result_o=0, zero_o=1, cout_o=0, overflow_o=0, done_o=0, busy_o=0.
  - All slice_* outputs are 0.
  - A reset during RUN aborts the operation: no done_o, no partial result visible.
- States:
  - IDLE: on start_i=1, latch src1/src2/ctrl, set idx=0, carry=0, go to RUN.
  - RUN: one bit per cycle. idx increments each cycle; after idx==WIDTH-1, go to DONE.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge N, done_o high during cycle N+WIDTH+1. With WIDTH=32, that is 33 cycles after acceptance.
- start_i while busy_o=1 is ignored (unless ALU_SERIAL_PENDING_EN is defined).
- Slice drive during RUN:
  - Operand bits are a_q[0] and b_q[0]; both operand registers shift right each cycle.
  - slice_operation_o = ctrl[1:0], except SLT, which drives 2'b10 (subtract) for every bit.
  - slice_cin_o = ctrl[2] at idx 0 and carry_q afterwards, for ADD/SUB/SLT; 0 for logic operations.
  - carry_q is loaded from slice_cout_i each cycle.
- Result assembly:
  - The result register shifts right, inserting slice_result_i at the MSB, so it is LSB-aligned after WIDTH cycles.
  - At idx==WIDTH-1, capture cin_msb = slice_cin_o, sum_msb = slice_result_i and cout_msb = slice_cout_i.
- Flags on entry to DONE:
  - ADD/SUB: result_o = assembled word; cout_o = cout_msb; overflow_o = cin_msb ^ cout_msb.
  - SLT: result_o = {WIDTH-1 zeros, sum_msb ^ overflow}; cout_o = cout_msb; overflow_o = 0.
  - Logic operations: cout_o = 0; overflow_o = 0.
  - Any unlisted ctrl code: runs the full WIDTH cycles; result_o = 0, zero_o = 1, cout_o = 0, overflow_o = 0.
- Outputs hold from DONE until the next request is accepted. They are not cleared at acceptance; they update only at the DONE entry edge.
- During IDLE, slice_* outputs are 0.

Optional Feature:
- Macro: ALU_SERIAL_PENDING_EN.
- Defined:
  - Adds a one-deep request buffer (pending flag, ctrl and both operands).
  - start_i while busy_o=1 and the buffer is empty is captured. Further starts while the buffer is full are dropped.
  - On leaving DONE, a pending request goes directly to RUN with idx=0, skipping IDLE, and the buffer clears.
  - pending_o (out, 1) reflects the pending flag.
  - Back-to-back operations therefore complete every WIDTH+1 cycles.
- Not defined: no buffer, no pending_o port; starts while busy are ignored.

Test Plan:
- Reset during RUN: ADD 5+7 started, rst_i pulsed low at idx 10 -> busy_o=0 immediately, no done_o, result_o=0, zero_o=1; a fresh ADD 5+7 then yields 12.
- ADD: 0x7FFFFFFF + 1 -> result 0x80000000, overflow_o=1, cout_o=0, done_o exactly 33 cycles after acceptance.
- SUB: 5 - 5 -> result 0, zero_o=1, cout_o=1, overflow_o=0.
- SLT: -1 vs 1 -> result 1. SLT 0x7FFFFFFF vs 0x80000000 -> result 0, showing overflow correction.
- Logic: NOR 0xF0F0F0F0, 0x0F0F0F00 -> 0x0000000F. NAND 0xFFFFFFFF, 0xFFFF0000 -> 0x0000FFFF. Both with cout_o=0.
- Start while busy: start_i pulsed mid-RUN -> ignored, and only one done_o. With ALU_SERIAL_PENDING_EN: ADD 1+2 then queued SUB 9-4 -> done_o pulses with 3 then 5, 33 cycles apart.
